prom_arbiter: RTL and testbench

- Shares the single-port 4-bit x 256 program ROM between two requesters: requester 0 is the display digit lookup and requester 1 is the alarm melody sequencer.
- Accepts one read at a time using round-robin arbitration.
- Drives the ROM address, chip enable, output enable and reset pins.
- Captures the ROM data one cycle after the address is sampled and returns it to the winning requester with a one-cycle valid pulse.

---
 rtl/prom_arbiter.sv | 132 +++++++++++++
 tb/tb_prom_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_arbiter.sv
// Round-robin arbiter sharing one single-port program ROM between the display
// digit lookup (requester 0) and the alarm melody sequencer (requester 1).
module prom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic              rvalid1,

    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    input  logic [DATA_W-1:0] rom_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              ack0_q;
    logic              ack1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              rom_ce_q;
    logic [ADDR_W-1:0] rom_ad_q;
    logic [DATA_W-1:0] rdata_q;

    logic              win_valid_d;
    logic              win_sel_d;
    logic [ADDR_W-1:0] win_addr_d;

    // Winner selection: a lone request wins outright; under contention the
    // requester that was not granted last time goes first.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win_valid_d = req0 | req1;
        win_sel_d   = 1'b0;
        if (req0 && req1) begin
            win_sel_d = ~last_grant_q;
        end else if (req1) begin
            win_sel_d = 1'b1;
        end
        win_addr_d = win_sel_d ? addr1 : addr0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rom_ce_q     <= 1'b0;
            rom_ad_q     <= '0;
            rdata_q      <= '0;
        end else begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (win_valid_d) begin
                        rom_ad_q     <= win_addr_d;
                        rom_ce_q     <= 1'b1;
                        ack0_q       <= ~win_sel_d;
                        ack1_q       <= win_sel_d;
                        last_grant_q <= win_sel_d;
                        owner_q      <= win_sel_d;
                        state_q      <= ISSUE;
                    end else begin
                        rom_ce_q <= 1'b0;
                    end
                end

                // ROM samples rom_ad at the edge closing this cycle; rom_ad is kept.
                ISSUE: begin
                    rom_ce_q <= 1'b0;
                    state_q  <= CAPTURE;
                end

                CAPTURE: begin
                    rdata_q   <= rom_dout;
                    rvalid0_q <= ~owner_q;
                    rvalid1_q <= owner_q;
                    state_q   <= IDLE;
                end

                default: begin
                    rom_ce_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign rom_ad    = rom_ad_q;
    assign rom_ce    = rom_ce_q;
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

endmodule

// File: tb/tb_prom_arbiter.sv
// Scoreboard bench for prom_arbiter: directed reads push expected grants and
// data; a monitor pops and compares whenever ack or rvalid appears.
module tb_prom_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic              ack0, ack1, rvalid0, rvalid1, busy;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] rom_ad;
    logic              rom_ce, rom_oce, rom_reset;
    logic [DATA_W-1:0] rom_dout = '0;

    prom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .ack0     (ack0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .addr1    (addr1),
        .ack1     (ack1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .busy     (busy),
        .rom_ad   (rom_ad),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_reset(rom_reset),
        .rom_dout (rom_dout)
    );

    always #5 clk = ~clk;

    // ROM image: only the low locations used by the bench are programmed.
    logic [DATA_W-1:0] rom_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;
        rom_mem[8'h00] = 4'h3;
        rom_mem[8'h04] = 4'h5;
        rom_mem[8'h08] = 4'h8;
        rom_mem[8'h10] = 4'h2;
        rom_mem[8'h11] = 4'h2;
    end
    always @(posedge clk) if (rom_ce) rom_dout <= rom_mem[rom_ad];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int ce_count = 0;

    typedef struct {
        logic              who;
        logic [DATA_W-1:0] data;
    } rv_t;

    rv_t  rvq [$];
    logic ackq [$];
    int   lat_q [$];
    logic [DATA_W-1:0] rd_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rv_t mk_rv(input logic who, input logic [DATA_W-1:0] data);
        rv_t r;
        r.who  = who;
        r.data = data;
        return r;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            rv_t e;
            @(posedge clk);
            #1;
            if (rom_ce) ce_count++;
            check("rom_oce", 32'(rom_oce), 32'd1);
            check("rom_reset", 32'(rom_reset), 32'(reset));
            if (ack0 || ack1) begin
                check("ack_expected", 32'(ackq.size() != 0), 32'd1);
                if (ackq.size() != 0) begin
                    logic w;
                    w = ackq.pop_front();
                    check("ack_who", 32'({ack1, ack0}), w ? 32'd2 : 32'd1);
                end
                lat_q.push_back(cyc);
            end
            if (rvalid0 || rvalid1) begin
                check("rvalid_expected", 32'(rvq.size() != 0), 32'd1);
                check("rvalid_latency_known", 32'(lat_q.size() != 0), 32'd1);
                if (lat_q.size() != 0) check("rvalid_latency", 32'(cyc - lat_q.pop_front()), 32'd2);
                if (rvq.size() != 0) begin
                    e = rvq.pop_front();
                    check("rvalid_who", 32'({rvalid1, rvalid0}), e.who ? 32'd2 : 32'd1);
                    check("rdata", 32'(rdata), 32'(e.data));
                    rd_model = e.data;
                end
            end else if (reset) begin
                rd_model = '0;
            end else begin
                check("rdata_hold", 32'(rdata), 32'(rd_model));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({ack0, ack1, rvalid0, rvalid1, rom_ce, busy}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rom_ad", 32'(rom_ad), 32'd0);
        reset = 1'b0;
        lat_q.delete();
    endtask

    task automatic wait_ack(input logic who, output int waited);
        logic got;
        got    = 1'b0;
        waited = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (who ? ack1 : ack0) begin
                waited = i;
                got    = 1'b1;
                break;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
    endtask

    // Single read by one requester into an idle arbiter.
    task automatic do_read(input logic who, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int w;
        ackq.push_back(who);
        rvq.push_back(mk_rv(who, d));
        @(negedge clk);
        if (who) begin req1 = 1'b1; addr1 = a; end
        else     begin req0 = 1'b1; addr0 = a; end
        wait_ack(who, w);
        check("ack_delay", 32'(w), 32'd1);
        check("issue_busy_ce", 32'({busy, rom_ce}), 32'd3);
        check("issue_rom_ad", 32'(rom_ad), 32'(a));
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Both requesters held high until n grants have been seen.
    task automatic contend(input int n);
        int seen;
        int last_c;
        seen   = 0;
        last_c = 0;
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        for (int b = 0; b < 40 && seen < n; b++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                if (seen > 0) check("ack_spacing", 32'(cyc - last_c), 32'd3);
                last_c = cyc;
                seen++;
            end
        end
        check("contend_grants", 32'(seen), 32'(n));
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int w;
        int ce0;

        do_reset();

        // Single read: 0x00 -> 0x3
        do_read(1'b0, 8'h00, 4'h3);

        // Contention from reset: grants 0,1,0,1
        do_reset();
        addr0 = 8'h04;
        addr1 = 8'h08;
        ackq.push_back(1'b0); rvq.push_back(mk_rv(1'b0, 4'h5));
        ackq.push_back(1'b1); rvq.push_back(mk_rv(1'b1, 4'h8));
        ackq.push_back(1'b0); rvq.push_back(mk_rv(1'b0, 4'h5));
        ackq.push_back(1'b1); rvq.push_back(mk_rv(1'b1, 4'h8));
        contend(4);

        // Back-to-back on requester 1 with req held and address stepped
        ce0 = ce_count;
        ackq.push_back(1'b1); rvq.push_back(mk_rv(1'b1, 4'h2));
        ackq.push_back(1'b1); rvq.push_back(mk_rv(1'b1, 4'h2));
        @(negedge clk);
        req1  = 1'b1;
        addr1 = 8'h10;
        wait_ack(1'b1, w);
        addr1 = 8'h11;
        wait_ack(1'b1, w);
        check("b2b_ack_spacing", 32'(w), 32'd3);
        check("b2b_rom_ad", 32'(rom_ad), 32'h11);
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_rom_ce_cycles", 32'(ce_count - ce0), 32'd2);

        // Upper / unprogrammed addresses
        do_read(1'b0, 8'hFF, 4'h0);
        do_read(1'b1, 8'h12, 4'h0);
        do_read(1'b0, 8'h04, 4'h5);
        do_read(1'b0, 8'h40, 4'h0);

        // Reset during ISSUE: the in-flight read must never return
        ackq.push_back(1'b0);
        @(negedge clk);
        req0  = 1'b1;
        addr0 = 8'h04;
        wait_ack(1'b0, w);
        check("midrst_in_issue", 32'({busy, rom_ce}), 32'd3);
        req0  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy_ce", 32'({busy, rom_ce}), 32'd0);
        reset = 1'b0;
        lat_q.delete();
        repeat (6) @(negedge clk);

        // After reset, contention grants requester 0 first
        addr0 = 8'h04;
        addr1 = 8'h08;
        ackq.push_back(1'b0); rvq.push_back(mk_rv(1'b0, 4'h5));
        ackq.push_back(1'b1); rvq.push_back(mk_rv(1'b1, 4'h8));
        contend(2);

        // Idle stability: nothing toggles, rdata holds (monitor checks rdata)
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", 32'({rom_ce, ack0, ack1, rvalid0, rvalid1, busy}), 32'd0);
        end
        check("idle_rdata", 32'(rdata), 32'h8);

        repeat (3) @(negedge clk);
        check("ackq_drained", 32'(ackq.size()), 32'd0);
        check("rvq_drained", 32'(rvq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
